// File: rtl/fab_clk_en_gen.sv
// fab_clk_en_gen
//   APB3-programmable clock-enable generator on the MSS fabric clock.
//   Produces N_CH independent single-cycle enable strobes. Each strobe has
//   period DIV[i]+1 cycles. No strobes are issued while the CCC is unlocked.
//
// Ports
//   FAB_CLK    in   1       fabric clock, rising edge
//   M2FRESETn  in   1       synchronous active-low reset
//   FAB_LOCK   in   1       CCC lock; low = clock not trusted
//   PSEL       in   1       APB3 select
//   PENABLE    in   1       APB3 access phase
//   PWRITE     in   1       APB3 write
//   PADDR      in   ADDR_W  APB3 byte address, [1:0] ignored
//   PWDATA     in   32      APB3 write data
//   PRDATA     out  32      APB3 read data, registered in the setup phase
//   PREADY     out  1       always 1
//   PSLVERR    out  1       unmapped access, access phase only
//   CLK_EN     out  N_CH    per-channel one-cycle enable strobe
//
// Register map
//   0x00 CTRL    [0] GEN, [1] RESTART (write-1, reads 0), [8+N_CH-1:8] CH_EN
//   0x04 STATUS  [0] live FAB_LOCK, [1] LOCK_LOST (sticky, W1C)
//   0x10+4*i     DIV[i] in [DIV_W-1:0]
module fab_clk_en_gen #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              FAB_CLK,
  input  logic              M2FRESETn,
  input  logic              FAB_LOCK,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [N_CH-1:0]   CLK_EN
);

  localparam int unsigned IW = ADDR_W - 2;

  logic             r_gen;
  logic             r_restart;
  logic [N_CH-1:0]  r_ch_en;
  logic             r_lost;
  logic [DIV_W-1:0] r_div [N_CH];
  logic [DIV_W-1:0] r_cnt [N_CH];
  logic [N_CH-1:0]  r_clk_en;
  logic [31:0]      r_prdata;

  logic [IW-1:0]    w_idx;
  logic             w_sel_ctrl;
  logic             w_sel_stat;
  logic [N_CH-1:0]  w_sel_div;
  logic             w_mapped;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic             w_rd_setup;
  logic             w_unused;

  assign w_idx      = PADDR[ADDR_W-1:2];
  assign w_wr       = PSEL & PENABLE & PWRITE;
  assign w_rd_setup = PSEL & ~PENABLE;

  // Address decode and read mux; unmapped addresses return 0.
  always_comb begin
    w_sel_ctrl = (w_idx == IW'(0));
    w_sel_stat = (w_idx == IW'(1));
    w_sel_div  = '0;
    w_rdata    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_sel_div[i] = (w_idx == IW'(4 + i));
    end
    w_mapped = w_sel_ctrl | w_sel_stat | (|w_sel_div);
    if (w_sel_ctrl) begin
      w_rdata[0]         = r_gen;
      w_rdata[8 +: N_CH] = r_ch_en;
    end
    if (w_sel_stat) begin
      w_rdata[0] = FAB_LOCK;
      w_rdata[1] = r_lost;
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_sel_div[i]) begin
        w_rdata[DIV_W-1:0] = r_div[i];
      end
    end
  end

  // Configuration registers and APB read register.
  always_ff @(posedge FAB_CLK) begin
    if (!M2FRESETn) begin
      r_gen     <= 1'b0;
      r_restart <= 1'b0;
      r_ch_en   <= '0;
      r_lost    <= 1'b0;
      r_prdata  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_div[i] <= '0;
      end
    end else begin
      r_restart <= 1'b0;
      if (w_wr && w_sel_ctrl) begin
        r_gen     <= PWDATA[0];
        r_restart <= PWDATA[1];
        r_ch_en   <= PWDATA[8 +: N_CH];
      end
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (w_wr && w_sel_div[i]) begin
          r_div[i] <= PWDATA[DIV_W-1:0];
        end
      end
      // Lock loss sets the sticky bit even if a clear is written this cycle.
      if (!FAB_LOCK) begin
        r_lost <= 1'b1;
      end else if (w_wr && w_sel_stat && PWDATA[1]) begin
        r_lost <= 1'b0;
      end
      if (w_rd_setup) begin
        r_prdata <= w_rdata;
      end
    end
  end

  // Channel counters. The reload value is sampled at reload time, so a DIV
  // write only affects the period after the one in progress. RESTART zeroes
  // every counter one edge after the CTRL write so active channels align.
  always_ff @(posedge FAB_CLK) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!M2FRESETn || !(r_gen && r_ch_en[i] && FAB_LOCK)) begin
        r_cnt[i]    <= '0;
        r_clk_en[i] <= 1'b0;
      end else begin
        r_clk_en[i] <= (r_cnt[i] == '0);
        if (r_restart) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == '0) begin
          r_cnt[i] <= r_div[i];
        end else begin
          r_cnt[i] <= r_cnt[i] - DIV_W'(1);
        end
      end
    end
  end

  assign PRDATA   = r_prdata;
  assign PREADY   = 1'b1;
  assign PSLVERR  = PSEL & PENABLE & ~w_mapped;
  assign CLK_EN   = r_clk_en;
  assign w_unused = &{1'b0, PADDR[1:0], PWDATA};

endmodule

// File: tb/tb_fab_clk_en_gen.sv
module tb_fab_clk_en_gen;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned ADDR_W = 8;

  logic              FAB_CLK   = 1'b0;
  logic              M2FRESETn = 1'b0;
  logic              FAB_LOCK  = 1'b1;
  logic              PSEL      = 1'b0;
  logic              PENABLE   = 1'b0;
  logic              PWRITE    = 1'b0;
  logic [ADDR_W-1:0] PADDR     = '0;
  logic [31:0]       PWDATA    = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [N_CH-1:0]   CLK_EN;

  fab_clk_en_gen #(
    .N_CH  (N_CH),
    .DIV_W (DIV_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .FAB_CLK  (FAB_CLK),
    .M2FRESETn(M2FRESETn),
    .FAB_LOCK (FAB_LOCK),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .CLK_EN   (CLK_EN)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the commit edge.
  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    #1;
    rd  = PRDATA;
    err = PSLVERR;
    @(posedge FAB_CLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        err;
    apb(1'b1, a, d, rd, err);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        err;
    apb(1'b0, a, 32'h0, rd, err);
    chk(name, rd, exp);
  endtask

  task automatic do_reset();
    M2FRESETn = 1'b0;
    tick();
    tick();
    M2FRESETn = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [3:0]  exp_en;
    logic [3:0]  rs_exp [5];
    bit          seen;

    vt[0]  = '{1'b0, 8'h00, 32'h0,        32'h0,    1'b0};
    vt[1]  = '{1'b0, 8'h04, 32'h0,        32'h1,    1'b0};
    vt[2]  = '{1'b1, 8'h10, 32'h1234,     32'h0,    1'b0};
    vt[3]  = '{1'b0, 8'h10, 32'h0,        32'h1234, 1'b0};
    vt[4]  = '{1'b1, 8'h1C, 32'hFFFFABCD, 32'h0,    1'b0};
    vt[5]  = '{1'b0, 8'h1C, 32'h0,        32'hABCD, 1'b0};
    vt[6]  = '{1'b1, 8'h00, 32'h0F03,     32'h0,    1'b0};
    vt[7]  = '{1'b0, 8'h00, 32'h0,        32'h0F01, 1'b0};
    vt[8]  = '{1'b0, 8'h08, 32'h0,        32'h0,    1'b1};
    vt[9]  = '{1'b1, 8'h20, 32'hFFFFFFFF, 32'h0,    1'b1};
    vt[10] = '{1'b0, 8'h20, 32'h0,        32'h0,    1'b1};
    vt[11] = '{1'b0, 8'h10, 32'h0,        32'h1234, 1'b0};
    vt[12] = '{1'b1, 8'h0C, 32'h5,        32'h0,    1'b1};
    vt[13] = '{1'b1, 8'h00, 32'h0,        32'h0,    1'b0};
    vt[14] = '{1'b0, 8'h00, 32'h0,        32'h0,    1'b0};
    vt[15] = '{1'b0, 8'h14, 32'h0,        32'h0,    1'b0};

    // Reset state
    M2FRESETn = 1'b0;
    tick();
    tick();
    chk("rst_clk_en", 32'(CLK_EN), 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h1);
    M2FRESETn = 1'b1;
    tick();

    // Register access table
    for (int i = 0; i < 16; i++) begin
      apb(vt[i].wr, vt[i].addr, vt[i].wdata, rd, err);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
      if (!vt[i].wr) chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
    end

    // Single channel, DIV0=3: strobe every 4 cycles, first 1 cycle after commit
    do_reset();
    wr(8'h10, 32'd3);
    wr(8'h00, 32'h101);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_en = ((k - 1) % 4 == 0) ? 4'b0001 : 4'b0000;
      chk($sformatf("div3_k%0d", k), 32'(CLK_EN), 32'(exp_en));
    end

    // DIV1=0 and DIV2=2 together, then RESTART phase alignment
    wr(8'h00, 32'h0);
    wr(8'h14, 32'd0);
    wr(8'h18, 32'd2);
    wr(8'h00, 32'h601);
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_en = 4'b0010 | (((k - 1) % 3 == 0) ? 4'b0100 : 4'b0000);
      chk($sformatf("ch12_k%0d", k), 32'(CLK_EN), 32'(exp_en));
    end
    tick();
    wr(8'h00, 32'h603);
    rs_exp[0] = 4'b0110; rs_exp[1] = 4'b0110; rs_exp[2] = 4'b0010;
    rs_exp[3] = 4'b0010; rs_exp[4] = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("restart_k%0d", k + 1), 32'(CLK_EN), 32'(rs_exp[k]));
    end

    // DIV change mid-period: 10-cycle period completes, then 2-cycle period
    wr(8'h00, 32'h0);
    wr(8'h10, 32'd9);
    wr(8'h00, 32'h101);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("div9_k%0d", k), 32'(CLK_EN), (k == 1) ? 32'h1 : 32'h0);
    end
    wr(8'h10, 32'd1);
    for (int k = 8; k <= 16; k++) begin
      tick();
      chk($sformatf("divchg_k%0d", k), 32'(CLK_EN),
          (k == 11 || k == 13 || k == 15) ? 32'h1 : 32'h0);
    end

    // Lock loss
    FAB_LOCK = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("nolock_k%0d", k), 32'(CLK_EN), 32'h0);
    end
    rd_chk("status_low", 8'h04, 32'h2);
    wr(8'h04, 32'h2);
    rd_chk("status_setwins", 8'h04, 32'h2);
    FAB_LOCK = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("relock_k%0d", k), 32'(CLK_EN), (k % 2 == 1) ? 32'h1 : 32'h0);
    end
    rd_chk("status_relock", 8'h04, 32'h3);
    wr(8'h04, 32'h2);
    rd_chk("status_clear", 8'h04, 32'h1);

    // Reset mid-strobe
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (CLK_EN[0]) seen = 1'b1;
    end
    chk("wait_strobe", 32'(seen), 32'h1);
    M2FRESETn = 1'b0;
    tick();
    chk("midrst_clk_en", 32'(CLK_EN), 32'h0);
    chk("midrst_prdata", PRDATA, 32'h0);
    M2FRESETn = 1'b1;
    tick();
    chk("postrst_clk_en", 32'(CLK_EN), 32'h0);
    rd_chk("postrst_ctrl", 8'h00, 32'h0);
    rd_chk("postrst_status", 8'h04, 32'h1);
    rd_chk("postrst_div0", 8'h10, 32'h0);
    rd_chk("postrst_div1", 8'h14, 32'h0);
    rd_chk("postrst_div2", 8'h18, 32'h0);
    rd_chk("postrst_div3", 8'h1C, 32'h0);
    tick();
    chk("postrst_idle", 32'(CLK_EN), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
